// File: rtl/AHB_package.sv
// Shared AHB-Lite definitions for slaves on this bus.
//   AHB_ADDR_WIDTH / AHB_DATA_WIDTH : bus widths
//   htrans_type, hsize_type         : transfer type and size encodings
//   HRESP_OKAY / HRESP_ERROR        : response encodings
//   SLAVE_WINDOW_BYTES              : decoder window size of one slave; the
//                                     address is taken modulo this window
package AHB_package;

  localparam int AHB_ADDR_WIDTH = 32;
  localparam int AHB_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_type;

  typedef enum logic [2:0] {
    HSIZE_BYTE       = 3'd0,
    HSIZE_HALFWORD   = 3'd1,
    HSIZE_WORD       = 3'd2,
    HSIZE_DOUBLEWORD = 3'd3,
    HSIZE_4WORD      = 3'd4,
    HSIZE_8WORD      = 3'd5,
    HSIZE_16WORD     = 3'd6,
    HSIZE_32WORD     = 3'd7
  } hsize_type;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam int SLAVE_WINDOW_BYTES = 4096;

  // NONSEQ and SEQ are the only transfer types that carry data.
  function automatic logic htrans_active(input htrans_type t);
    return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_byte_strobe.sv
// Byte-lane strobe and alignment check for one AHB address phase.
//   addr_lo   : haddr[1:0]
//   hsize     : transfer size
//   strobe    : little-endian byte lanes touched (bit n = hwdata[8n+7:8n])
//   unaligned : address not aligned to hsize
// Sizes above WORD give strobe 0 and unaligned 0; the caller flags them.
module ahb_byte_strobe
  import AHB_package::*;
(
  input  logic [1:0] addr_lo,
  input  hsize_type  hsize,
  output logic [3:0] strobe,
  output logic       unaligned
);

  always_comb begin
    strobe    = 4'b0000;
    unaligned = 1'b0;
    case (hsize)
      HSIZE_BYTE: begin
        strobe = 4'b0001 << addr_lo;
      end
      HSIZE_HALFWORD: begin
        strobe    = addr_lo[1] ? 4'b1100 : 4'b0011;
        unaligned = addr_lo[0];
      end
      HSIZE_WORD: begin
        strobe    = 4'b1111;
        unaligned = |addr_lo;
      end
      default: begin
        strobe    = 4'b0000;
        unaligned = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ahb_slave_regbank.sv
// AHB-Lite slave exposing REG_NUM 32-bit registers.
//   hclk, hreset          : clock, asynchronous active-high reset
//   hsel, haddr, htrans,
//   hwrite, hsize, hready : address phase (taken when hsel & hready & active)
//   hwdata                : write data, valid in the data phase
//   hreadyout, hresp      : this slave's data-phase ready / response
//   hrdata                : read data, non-zero only in a read's final cycle
//   dbg_state             : current FSM state (S_IDLE=0 .. S_ERR2=3)
//
// Handshake: an address phase is a transfer request that is taken on the
// rising edge where hsel & hready & (NONSEQ|SEQ) hold. Its data phase then
// runs until the slave drives hreadyout=1; that cycle is the final data cycle
// (a write commits at its closing edge, a read presents hrdata in it), and it
// is also the cycle in which the next address phase may be taken.
module ahb_slave_regbank
  import AHB_package::*;
#(
  parameter int REG_NUM     = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                      hclk,
  input  logic                      hreset,
  input  logic                      hsel,
  input  logic [AHB_ADDR_WIDTH-1:0] haddr,
  input  htrans_type                htrans,
  input  logic                      hwrite,
  input  hsize_type                 hsize,
  input  logic [AHB_DATA_WIDTH-1:0] hwdata,
  input  logic                      hready,
  output logic                      hreadyout,
  output logic                      hresp,
  output logic [AHB_DATA_WIDTH-1:0] hrdata,
  output logic [1:0]                dbg_state
);

  localparam int IDX_W = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
  localparam int WIN_W = $clog2(SLAVE_WINDOW_BYTES / 4);
  localparam logic [WIN_W-1:0] REG_LIMIT = WIN_W'(REG_NUM);
  localparam logic [2:0] WAIT_INIT = 3'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR1 = 2'd2,
    S_ERR2 = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [2:0]                cnt_q, cnt_d;
  logic                      pend_q, pend_d;     // OKAY data phase outstanding
  logic                      write_q, write_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [3:0]                strb_q, strb_d;
  logic                      hreadyout_q, hreadyout_d;
  logic                      hresp_q, hresp_d;
  logic [AHB_DATA_WIDTH-1:0] regs_q [REG_NUM];
  logic [AHB_DATA_WIDTH-1:0] regs_d [REG_NUM];

  logic [WIN_W-1:0] win_idx;
  logic [3:0]       lane_strobe;
  logic             unaligned;
  logic             addr_err;
  logic             accept;
  logic             final_cycle;
  logic             unused_addr_bits;

  ahb_byte_strobe u_strobe (
    .addr_lo   (haddr[1:0]),
    .hsize     (hsize),
    .strobe    (lane_strobe),
    .unaligned (unaligned)
  );

  // Word index inside the slave window; the decoder already matched the
  // upper address bits, so they only alias.
  assign win_idx          = haddr[WIN_W+1:2];
  assign unused_addr_bits = ^{haddr[AHB_ADDR_WIDTH-1:WIN_W+2], win_idx[WIN_W-1:IDX_W]};

  assign accept   = hsel & hready & htrans_active(htrans);
  assign addr_err = (hsize > HSIZE_WORD) | unaligned | (win_idx >= REG_LIMIT);

  // A pending OKAY transfer sitting in S_IDLE is in its final data cycle:
  // either there are no wait states, or S_WAIT has just counted out.
  assign final_cycle = (state_q == S_IDLE) && pend_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    write_d = write_q;
    idx_d   = idx_q;
    strb_d  = strb_q;
    regs_d  = regs_q;

    if (final_cycle && write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (strb_q[b]) regs_d[idx_q][8*b +: 8] = hwdata[8*b +: 8];
      end
    end

    case (state_q)
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = S_IDLE;
      end
      S_ERR1: begin
        state_d = S_ERR2;
        pend_d  = 1'b0;
      end
      default: begin
        // S_IDLE and S_ERR2 are the cycles where hreadyout=1, so a new
        // address phase can be taken here.
        if (accept) begin
          write_d = hwrite;
          idx_d   = win_idx[IDX_W-1:0];
          strb_d  = lane_strobe;
          if (addr_err) begin
            state_d = S_ERR1;
            pend_d  = 1'b0;
          end else if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
            pend_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
            pend_d  = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
          pend_d  = 1'b0;
        end
      end
    endcase

    hreadyout_d = !((state_d == S_WAIT) || (state_d == S_ERR1));
    hresp_d     = ((state_d == S_ERR1) || (state_d == S_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      pend_q      <= 1'b0;
      write_q     <= 1'b0;
      idx_q       <= '0;
      strb_q      <= 4'b0000;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      write_q     <= write_d;
      idx_q       <= idx_d;
      strb_q      <= strb_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      for (int i = 0; i < REG_NUM; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign hreadyout = hreadyout_q;
  assign hresp     = hresp_q;
  assign hrdata    = (final_cycle && !write_q) ? regs_q[idx_q] : '0;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ahb_slave_regbank.sv
module tb_ahb_slave_regbank;
  import AHB_package::*;

  // ---------------- clock / reset ----------------
  logic hclk = 1'b0;
  logic hreset;
  always #5 hclk = ~hclk;

  // ---------------- bus shared by both instances ----------------
  logic        hsel0, hsel2;
  logic [31:0] haddr;
  htrans_type  htrans;
  logic        hwrite;
  hsize_type   hsize;
  logic [31:0] hwdata;

  logic        hreadyout0, hresp0, hreadyout2, hresp2;
  logic [31:0] hrdata0, hrdata2;
  logic [1:0]  dbg0, dbg2;

  ahb_slave_regbank #(.REG_NUM(16), .WAIT_STATES(0)) dut0 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hreadyout0),
    .hreadyout(hreadyout0), .hresp(hresp0), .hrdata(hrdata0), .dbg_state(dbg0)
  );

  ahb_slave_regbank #(.REG_NUM(16), .WAIT_STATES(2)) dut2 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel2), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hreadyout2),
    .hreadyout(hreadyout2), .hresp(hresp2), .hrdata(hrdata2), .dbg_state(dbg2)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  // ---------------- driver ----------------
  // One NONSEQ transfer, then IDLE. Records hresp per data cycle (bit i =
  // cycle i), the number of data cycles (bounded at 16) and final hrdata.
  task automatic xfer(input int dut, input logic wr, input logic [31:0] addr,
                      input hsize_type sz, input logic [31:0] wd,
                      output int n_cyc, output logic [15:0] hist,
                      output logic [31:0] rd, output logic early_nz);
    logic r, p;
    logic [31:0] d;
    @(posedge hclk); #1;
    hsel0 = (dut == 0); hsel2 = (dut == 2);
    htrans = HTRANS_NONSEQ; haddr = addr; hwrite = wr; hsize = sz;
    @(posedge hclk); #1;
    hsel0 = 1'b0; hsel2 = 1'b0; htrans = HTRANS_IDLE; hwdata = wd;
    n_cyc = 0; hist = '0; rd = '0; early_nz = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge hclk);
      r = (dut == 2) ? hreadyout2 : hreadyout0;
      p = (dut == 2) ? hresp2 : hresp0;
      d = (dut == 2) ? hrdata2 : hrdata0;
      hist[n_cyc] = p;
      n_cyc++;
      if (r) begin
        rd = d;
        break;
      end
      if (d != 0) early_nz = 1'b1;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          dut;
    logic        wr;
    logic [31:0] addr;
    hsize_type   sz;
    logic [31:0] wd;
    logic        err;
    logic [31:0] exp_rd;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  initial begin
    int          n_cyc;
    logic [15:0] hist;
    logic [31:0] rd;
    logic        early_nz;
    int          exp_n;
    logic [31:0] exp_rd;

    vecs[0]  = '{0, 1'b1, 32'h0000_0008, HSIZE_WORD,       32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[1]  = '{0, 1'b0, 32'h0000_0008, HSIZE_WORD,       32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{0, 1'b1, 32'h0000_0008, HSIZE_WORD,       32'h1122_3344, 1'b0, 32'h0};
    vecs[3]  = '{0, 1'b1, 32'h0000_000A, HSIZE_HALFWORD,   32'hA5A5_0000, 1'b0, 32'h0};
    vecs[4]  = '{0, 1'b0, 32'h0000_0008, HSIZE_WORD,       32'h0,         1'b0, 32'hA5A5_3344};
    vecs[5]  = '{0, 1'b1, 32'h0000_0002, HSIZE_WORD,       32'hFFFF_FFFF, 1'b1, 32'h0};
    vecs[6]  = '{0, 1'b0, 32'h0000_0000, HSIZE_WORD,       32'h0,         1'b0, 32'h0};
    vecs[7]  = '{0, 1'b1, 32'h0000_0040, HSIZE_WORD,       32'hFFFF_FFFF, 1'b1, 32'h0};
    vecs[8]  = '{0, 1'b1, 32'h0000_0008, HSIZE_DOUBLEWORD, 32'hFFFF_FFFF, 1'b1, 32'h0};
    vecs[9]  = '{0, 1'b0, 32'h0000_0008, HSIZE_WORD,       32'h0,         1'b0, 32'hA5A5_3344};
    vecs[10] = '{0, 1'b1, 32'h0000_000D, HSIZE_BYTE,       32'h0000_7700, 1'b0, 32'h0};
    vecs[11] = '{0, 1'b0, 32'h0000_000C, HSIZE_WORD,       32'h0,         1'b0, 32'h0000_7700};
    vecs[12] = '{0, 1'b1, 32'h0000_0001, HSIZE_HALFWORD,   32'hFFFF_FFFF, 1'b1, 32'h0};
    vecs[13] = '{0, 1'b0, 32'h0000_0000, HSIZE_WORD,       32'h0,         1'b0, 32'h0};
    vecs[14] = '{0, 1'b1, 32'h0000_1004, HSIZE_WORD,       32'hCAFE_F00D, 1'b0, 32'h0};
    vecs[15] = '{0, 1'b0, 32'h0000_0004, HSIZE_WORD,       32'h0,         1'b0, 32'hCAFE_F00D};
    vecs[16] = '{2, 1'b0, 32'h0000_0000, HSIZE_WORD,       32'h0,         1'b0, 32'h0};
    vecs[17] = '{2, 1'b1, 32'h0000_0010, HSIZE_WORD,       32'h1234_5678, 1'b0, 32'h0};
    vecs[18] = '{2, 1'b0, 32'h0000_0010, HSIZE_WORD,       32'h0,         1'b0, 32'h1234_5678};
    vecs[19] = '{2, 1'b0, 32'h0000_0044, HSIZE_WORD,       32'h0,         1'b1, 32'h0};
    vecs[20] = '{2, 1'b1, 32'h0000_003E, HSIZE_HALFWORD,   32'hBEEF_0000, 1'b0, 32'h0};
    vecs[21] = '{2, 1'b0, 32'h0000_003C, HSIZE_WORD,       32'h0,         1'b0, 32'hBEEF_0000};

    // reset values
    hreset = 1'b1;
    hsel0 = 1'b0; hsel2 = 1'b0; haddr = '0; htrans = HTRANS_IDLE;
    hwrite = 1'b0; hsize = HSIZE_WORD; hwdata = '0;
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    check("reset hreadyout0", {31'b0, hreadyout0}, 32'd1);
    check("reset hresp0",     {31'b0, hresp0},     32'd0);
    check("reset hrdata0",    hrdata0,             32'd0);
    check("reset state0",     {30'b0, dbg0},       32'd0);
    check("reset hreadyout2", {31'b0, hreadyout2}, 32'd1);
    check("reset hrdata2",    hrdata2,             32'd0);
    @(posedge hclk); #1;
    hreset = 1'b0;

    // table-driven single transfers
    for (int i = 0; i < NV; i++) begin
      if (!vecs[i].wr && !vecs[i].err) exp_q.push_back(vecs[i].exp_rd);
      xfer(vecs[i].dut, vecs[i].wr, vecs[i].addr, vecs[i].sz, vecs[i].wd,
           n_cyc, hist, rd, early_nz);
      exp_n = vecs[i].err ? 2 : ((vecs[i].dut == 2) ? 3 : 1);
      check($sformatf("v%0d data cycles", i), n_cyc, exp_n);
      check($sformatf("v%0d hresp history", i), {16'b0, hist}, vecs[i].err ? 32'h3 : 32'h0);
      check($sformatf("v%0d hrdata early", i), {31'b0, early_nz}, 32'd0);
      exp_rd = (!vecs[i].wr && !vecs[i].err) ? exp_q.pop_front() : 32'h0;
      check($sformatf("v%0d hrdata", i), rd, exp_rd);
    end

    // pipelined write then read of the same register, then IDLE with hsel
    @(posedge hclk); #1;
    hsel0 = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h04; hwrite = 1'b1; hsize = HSIZE_WORD;
    @(posedge hclk); #1;
    hwrite = 1'b0; hwdata = 32'h0BAD_F00D;
    @(negedge hclk);
    check("b2b wr ready", {31'b0, hreadyout0}, 32'd1);
    check("b2b wr hrdata", hrdata0, 32'd0);
    @(posedge hclk); #1;
    htrans = HTRANS_IDLE; hwdata = 32'h0;
    @(negedge hclk);
    check("b2b rd ready", {31'b0, hreadyout0}, 32'd1);
    check("b2b rd hresp", {31'b0, hresp0}, 32'd0);
    check("b2b rd hrdata", hrdata0, 32'h0BAD_F00D);
    @(posedge hclk); #1;
    @(negedge hclk);
    check("idle hsel ready", {31'b0, hreadyout0}, 32'd1);
    check("idle hsel hresp", {31'b0, hresp0}, 32'd0);
    check("idle hsel hrdata", hrdata0, 32'd0);
    hsel0 = 1'b0;

    // BUSY on the wait-state slave still answers with zero wait
    @(posedge hclk); #1;
    hsel2 = 1'b1; htrans = HTRANS_BUSY; haddr = 32'h10; hwrite = 1'b0;
    @(posedge hclk); #1;
    hsel2 = 1'b0; htrans = HTRANS_IDLE;
    @(negedge hclk);
    check("busy ready2", {31'b0, hreadyout2}, 32'd1);
    check("busy hresp2", {31'b0, hresp2}, 32'd0);

    // reset pulsed while a write sits in S_WAIT
    @(posedge hclk); #1;
    hsel2 = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h14; hwrite = 1'b1; hsize = HSIZE_WORD;
    @(posedge hclk); #1;
    hsel2 = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'hFFFF_0000;
    @(negedge hclk);
    check("wait before reset", {31'b0, hreadyout2}, 32'd0);
    #1 hreset = 1'b1;
    #1;
    check("async reset ready2", {31'b0, hreadyout2}, 32'd1);
    check("async reset hresp2", {31'b0, hresp2}, 32'd0);
    check("async reset hrdata2", hrdata2, 32'd0);
    check("async reset state2", {30'b0, dbg2}, 32'd0);
    @(posedge hclk); #1;
    @(posedge hclk); #1;
    hreset = 1'b0;

    xfer(2, 1'b0, 32'h14, HSIZE_WORD, 32'h0, n_cyc, hist, rd, early_nz);
    check("post-reset rd2 cycles", n_cyc, 32'd3);
    check("post-reset rd2 0x14", rd, 32'd0);
    xfer(2, 1'b0, 32'h10, HSIZE_WORD, 32'h0, n_cyc, hist, rd, early_nz);
    check("post-reset rd2 0x10", rd, 32'd0);
    xfer(0, 1'b0, 32'h08, HSIZE_WORD, 32'h0, n_cyc, hist, rd, early_nz);
    check("post-reset rd0 0x08", rd, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ahb_slave_regbank.md
AHB_SLAVE_REGBANK -- requirements
Module: ahb_slave_regbank

Interface
REQ-001 Parameter: REG_NUM, 16, number of 32-bit registers (power of two, 2..256).
REQ-002 Parameter: WAIT_STATES, 0, wait cycles inserted in every OKAY data phase (0..7).
REQ-003 hclk  input  1  bus clock, all state on rising edge.
REQ-004 hreset  input  1  reset, asynchronous, active-high.
REQ-005 hsel  input  1  slave select; one bit of the decoder's hreq vector.
REQ-006 haddr  input  AHB_ADDR_WIDTH  address-phase address.
REQ-007 htrans  input  htrans_type  IDLE/BUSY/NONSEQ/SEQ.
REQ-008 hwrite  input  1  1 = write.
REQ-009 hsize  input  hsize_type  transfer size.
REQ-010 hwdata  input  AHB_DATA_WIDTH  write data, valid in data phase.
REQ-011 hready  input  1  bus-level ready; address phase is taken only when high.
REQ-012 hreadyout  output  1  this slave's ready.
REQ-013 hresp  output  1  0 = OKAY, 1 = ERROR.
REQ-014 hrdata  output  AHB_DATA_WIDTH  read data.

Function
REQ-015 An address phase SHALL be accepted when hsel & hready & htrans is NONSEQ or SEQ; the slave samples haddr, hwrite, hsize and a computed error flag.
REQ-016 The error flag SHALL be set when hsize > WORD, when the address is unaligned for hsize, or when haddr[AHB_ADDR_WIDTH-1:2] modulo the slave window is >= REG_NUM.
REQ-017 An IDLE or BUSY transfer, or one with hsel low, SHALL produce a zero-wait OKAY response: hreadyout=1, hresp=0.
REQ-018 FSM states: S_IDLE, S_WAIT, S_ERR1, S_ERR2.
REQ-019 From S_IDLE, or from any final data cycle: an accepted transfer goes to S_ERR1 if its error flag is set.
REQ-020 Otherwise, with no error flag, it goes to S_WAIT if WAIT_STATES>0, else it stays in or returns to S_IDLE.
REQ-021 With no accepted transfer, the FSM goes to S_IDLE.
REQ-022 S_WAIT SHALL drive hreadyout=0 and hresp=0 for exactly WAIT_STATES cycles, counted by a down-counter.
REQ-023 The final OKAY data cycle SHALL follow S_WAIT with hreadyout=1, hresp=0.
REQ-024 ERROR SHALL be a two-cycle response: S_ERR1 drives hresp=1, hreadyout=0; S_ERR2 drives hresp=1, hreadyout=1; S_ERR2 then exits as in REQ-019..REQ-021.
REQ-025 Writes SHALL update the register only in the final OKAY data cycle, using little-endian byte lanes from haddr[1:0] and hsize (BYTE: 1 lane, HALFWORD: 2 lanes, WORD: 4 lanes).
REQ-026 Errored transfers SHALL never modify registers.
REQ-027 Reads SHALL drive hrdata = full register word in the final OKAY data cycle; hrdata SHALL be 0 in all other cycles.
REQ-028 A read whose address phase overlaps the data phase of a write to the same register SHALL return the newly written value.
REQ-029 While hreadyout=0, new address phases SHALL be ignored because hready is low.
REQ-030 hreset asserted mid-transfer SHALL abort the transfer; the pending write SHALL NOT be committed.

Reset
REQ-031 On hreset the outputs SHALL be: hreadyout=1, hresp=0, hrdata=0.
REQ-032 On hreset the internal state SHALL be: all registers 0, FSM S_IDLE, wait counter 0, sampled control cleared.
REQ-033 Reset assertion SHALL act asynchronously; release SHALL take effect on the next hclk edge.

Structure
REQ-034 htrans_type, hsize_type, the hresp encodings, AHB_ADDR_WIDTH and AHB_DATA_WIDTH SHALL come from AHB_package; no local redefinition.
REQ-035 Byte-lane strobe and alignment-check logic SHALL live in one sub-module, ahb_byte_strobe: inputs haddr[1:0] and hsize; outputs a 4-bit strobe and an unaligned flag.
REQ-036 The FSM state enum SHALL be local to ahb_slave_regbank.

Verification
REQ-037 WAIT_STATES=0: NONSEQ WORD write 32'hDEAD_BEEF to 0x08, then read 0x08 -> hreadyout stays 1, hrdata=32'hDEAD_BEEF in the read data phase.
REQ-038 WAIT_STATES=2: single read -> data phase hreadyout=0,0,1 with hresp=0 throughout.
REQ-039 Write HALFWORD 16'hA5A5 to 0x0A over a register holding 0x1122_3344 -> read returns 32'hA5A5_3344.
REQ-040 Error cases -> each gives ERR1 (hresp=1, hreadyout=0) then ERR2 (hresp=1, hreadyout=1), with the register unchanged:
- write WORD to 0x02 (unaligned);
- write with index REG_NUM (out of range);
- hsize=DOUBLEWORD.
REQ-041 Back-to-back write 0x04 then read 0x04 (pipelined) -> read returns the new value; an IDLE with hsel=1 gives OKAY with zero wait.
REQ-042 hreset pulsed during S_WAIT of a write -> outputs return to their reset values immediately; a later read of that address returns 0.
